// File: rtl/tetris_input_if.sv
// tetris_input_if: raw push-buttons and game enable in, one-cycle move requests out
interface tetris_input_if;
    logic game_en;
    logic btn_down;
    logic btn_left;
    logic btn_right;
    logic btn_rotate;
    logic down;
    logic left;
    logic right;
    logic rotate;
    modport master (output game_en, btn_down, btn_left, btn_right, btn_rotate, input down, left, right, rotate);
    modport slave (input game_en, btn_down, btn_left, btn_right, btn_rotate, output down, left, right, rotate);
endinterface

// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: sync, debounce, edge pulse and DAS/ARR auto-repeat for the four game buttons (gm_clk, gm_rst, io.slave)
module tetris_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int DAS_DELAY = 10,
    parameter int ARR_PERIOD = 3
) (
    input logic gm_clk,
    input logic gm_rst,
    tetris_input_if.slave io
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RMAX = DAS_DELAY > ARR_PERIOD ? DAS_DELAY : ARR_PERIOD;
    localparam int RW = $clog2(RMAX) + 1;
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HELD} state_t;
    logic [3:0] btn, db, raw, out_q;
    assign btn = {io.btn_rotate, io.btn_right, io.btn_left, io.btn_down};
    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic s1, s2, d;
        logic [DW-1:0] dcnt;
        logic [RW-1:0] rcnt, rcnt_n;
        state_t st, st_n;
        logic p;
        always_ff @(posedge gm_clk) begin
            if (gm_rst) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
                d <= 1'b0;
                dcnt <= '0;
            end else begin
                s1 <= btn[i];
                s2 <= s1;
                if (s2 == d) dcnt <= '0;
                else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    d <= s2;
                    dcnt <= '0;
                end else dcnt <= dcnt + 1'b1;
            end
        end
        assign db[i] = d;
        // release is tested before the terminal count so it wins over a due pulse
        always_comb begin
            st_n = st;
            rcnt_n = rcnt;
            p = 1'b0;
            if (!io.game_en) st_n = IDLE;
            else case (st)
                IDLE: if (d) begin
                    p = 1'b1;
                    rcnt_n = '0;
                    st_n = (i == 3) ? HELD : DELAY;
                end
                DELAY: if (!d) st_n = IDLE;
                else if (rcnt == RW'(DAS_DELAY - 1)) begin
                    p = 1'b1;
                    rcnt_n = '0;
                    st_n = REPEAT;
                end else rcnt_n = rcnt + 1'b1;
                REPEAT: if (!d) st_n = IDLE;
                else if (rcnt == RW'(ARR_PERIOD - 1)) begin
                    p = 1'b1;
                    rcnt_n = '0;
                end else rcnt_n = rcnt + 1'b1;
                HELD: st_n = d ? HELD : IDLE;
            endcase
        end
        always_ff @(posedge gm_clk) begin
            if (gm_rst) begin
                st <= IDLE;
                rcnt <= '0;
            end else begin
                st <= st_n;
                rcnt <= rcnt_n;
            end
        end
        assign raw[i] = p;
    end
    // left and right cancel each other while the opposite button is held
    always_ff @(posedge gm_clk) begin
        if (gm_rst) out_q <= '0;
        else out_q <= {raw[3], raw[2] & ~db[1], raw[1] & ~db[2], raw[0]} & {4{io.game_en}};
    end
    assign io.down = out_q[0];
    assign io.left = out_q[1];
    assign io.right = out_q[2];
    assign io.rotate = out_q[3];
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb_tetris_input_ctrl: per-cycle vector table of inputs and expected request pulses
module tb_tetris_input_ctrl;
  typedef struct {
    logic rst;
    logic en;
    logic [3:0] btn;
    logic [3:0] exp;
  } vec_t;
  localparam int D = 0, L = 1, R = 2, ROT = 3;
  logic gm_clk = 1'b0;
  logic gm_rst = 1'b1;
  tetris_input_if io ();
  tetris_input_ctrl dut (.gm_clk(gm_clk), .gm_rst(gm_rst), .io(io));
  always #5 gm_clk = ~gm_clk;
  vec_t vec [0:1023];
  int nv = 0;
  int base = 0;
  int napplied = 0;
  int nmis = 0;
  int waited = 0;
  logic seen = 1'b0;
  logic [3:0] got;
  task automatic seg(input int len);
    for (int k = 0; k < 2; k++) begin
      vec[nv] = '{rst: 1'b1, en: 1'b1, btn: 4'h0, exp: 4'h0};
      nv++;
    end
    base = nv;
    for (int k = 0; k < len; k++) begin
      vec[nv] = '{rst: 1'b0, en: 1'b1, btn: 4'h0, exp: 4'h0};
      nv++;
    end
  endtask
  task automatic hold(input int b, input int from, input int to);
    for (int e = from; e <= to; e++) vec[base + e].btn[b] = 1'b1;
  endtask
  task automatic pulse(input int b, input int e);
    vec[base + e].exp[b] = 1'b1;
  endtask
  initial begin
    io.game_en = 1'b1;
    io.btn_down = 1'b0;
    io.btn_left = 1'b0;
    io.btn_right = 1'b0;
    io.btn_rotate = 1'b0;
    seg(50);
    seg(80);
    hold(ROT, 10, 49);
    pulse(ROT, 14);
    hold(D, 10, 15);
    pulse(D, 14);
    hold(ROT, 60, 69);
    pulse(ROT, 64);
    seg(50);
    hold(L, 0, 27);
    pulse(L, 4); pulse(L, 14); pulse(L, 17); pulse(L, 20);
    pulse(L, 23); pulse(L, 26); pulse(L, 29);
    seg(45);
    for (int e = 0; e < 40; e += 2) hold(D, e, e);
    seg(60);
    hold(L, 0, 44);
    hold(R, 8, 29);
    pulse(L, 4); pulse(L, 35); pulse(L, 38); pulse(L, 41); pulse(L, 44); pulse(L, 47);
    seg(50);
    hold(D, 0, 37);
    for (int e = 0; e < 20; e++) vec[base + e].en = 1'b0;
    pulse(D, 20); pulse(D, 30); pulse(D, 33); pulse(D, 36); pulse(D, 39);
    seg(30);
    hold(L, 0, 29);
    vec[base + 8].rst = 1'b1;
    pulse(L, 4); pulse(L, 13); pulse(L, 23); pulse(L, 26); pulse(L, 29);
    for (int i = 0; i < nv; i++) begin
      gm_rst = vec[i].rst;
      io.game_en = vec[i].en;
      {io.btn_rotate, io.btn_right, io.btn_left, io.btn_down} = vec[i].btn;
      @(posedge gm_clk);
      #1;
      got = {io.rotate, io.right, io.left, io.down};
      napplied++;
      if (got !== vec[i].exp) begin
        nmis++;
        $display("FAIL vec %0d {rot,r,l,d}: got %b expected %b", i, got, vec[i].exp);
      end
    end
    gm_rst = 1'b1;
    io.game_en = 1'b1;
    {io.btn_rotate, io.btn_right, io.btn_left, io.btn_down} = 4'h0;
    @(posedge gm_clk);
    #1;
    got = {io.rotate, io.right, io.left, io.down};
    if (got !== 4'h0) begin
      nmis++;
      $display("FAIL reset state: got %b expected 0000", got);
    end
    gm_rst = 1'b0;
    io.btn_rotate = 1'b1;
    while (!seen && waited < 20) begin
      @(posedge gm_clk);
      #1;
      waited++;
      seen = io.rotate;
    end
    if (!seen) begin
      nmis++;
      $display("FAIL timeout: no rotate pulse within 20 cycles of press");
    end
    $display("== %0d vectors applied, %0d miscompares ==", napplied, nmis);
    $finish;
  end
endmodule
